// File: rtl/multiport_reg_file_if.sv
// Bus bundle between decode/writeback (master) and the multi-port register file (slave).
interface multiport_reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                    stall_i;
    logic [NUM_RD*AW-1:0]    rd_addr_i;
    logic [NUM_WR-1:0]       wr_en_i;
    logic [NUM_WR*AW-1:0]    wr_addr_i;
    logic [NUM_WR*WIDTH-1:0] wr_data_i;
    logic [WIDTH-1:0]        pc_i;
    logic [NUM_RD*WIDTH-1:0] rd_data_o;
    logic [WIDTH-1:0]        pc_o;

    modport master (
        output stall_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, pc_i,
        input  rd_data_o, pc_o
    );

    modport slave (
        input  stall_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, pc_i,
        output rd_data_o, pc_o
    );
endinterface

// File: rtl/multiport_reg_file.sv
// Parametrised multi-port register file: registered write-first reads, stall hold of the
// read addresses and pc, optional hard-wired zero register.
module multiport_reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multiport_reg_file_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];
    logic [NUM_RD*AW-1:0]    held_q;
    logic [NUM_RD*AW-1:0]    held_d;
    logic [NUM_RD*WIDTH-1:0] rd_data_q;
    logic [NUM_RD*WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0]        pc_q;
    logic [WIDTH-1:0]        pc_d;

    // Merge this cycle's writes; later ports override earlier ones, zero register is never stored.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en_i[j] && (32'(bus.wr_addr_i[j*AW +: AW]) == r) && (r != ZERO_REG)) begin
                    regs_d[r] = bus.wr_data_i[j*WIDTH +: WIDTH];
                end else begin
                    regs_d[r] = regs_d[r];
                end
            end
        end
    end

    // Pick live or held address per port, then read the post-write value so writes forward.
    always_comb begin
        held_d    = held_q;
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (bus.stall_i) begin
                held_d[k*AW +: AW] = held_q[k*AW +: AW];
            end else begin
                held_d[k*AW +: AW] = bus.rd_addr_i[k*AW +: AW];
            end
            for (int r = 0; r < DEPTH; r++) begin
                if ((32'(held_d[k*AW +: AW]) == r) && (r != ZERO_REG)) begin
                    rd_data_d[k*WIDTH +: WIDTH] = regs_d[r];
                end else begin
                    rd_data_d[k*WIDTH +: WIDTH] = rd_data_d[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Program counter travels with the captured addresses and freezes with them.
    always_comb begin
        if (bus.stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = bus.pc_i;
        end
    end

    // State registers; reset clears everything and drops any write presented meanwhile.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            held_q    <= '0;
            rd_data_q <= '0;
            pc_q      <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            held_q    <= held_d;
            rd_data_q <= rd_data_d;
            pc_q      <= pc_d;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.pc_o      = pc_q;
endmodule
